// File: rtl/eth_mac_tx.sv
// Byte-wide Ethernet transmit framer: preamble/SFD, payload, optional padding, CRC-32 FCS and inter-frame gap.
// Define ETH_TX_PAD_EN to pad short frames up to MIN_PAYLOAD bytes before the FCS.
module eth_mac_tx #(
    parameter int IFG_BYTES   = 12,
    parameter int MIN_PAYLOAD = 60
) (
    input  logic       clk_125mhz,
    input  logic       reset,
    input  logic [1:0] phy_speed_status,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    input  logic       s_axis_tlast,
    input  logic       s_axis_tuser,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       tx_busy,
    output logic       tx_underflow
);

`ifdef ETH_TX_PAD_EN
    localparam bit PAD_ENABLE = 1'b1;
`else
    localparam bit PAD_ENABLE = 1'b0;
`endif

    localparam logic [31:0] CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
    localparam logic [11:0] MIN_LEN  = 12'(MIN_PAYLOAD);
    localparam int          IFG_W    = $clog2(IFG_BYTES * 100 + 1);
    localparam logic [IFG_W-1:0] IFG_10M  = IFG_W'(IFG_BYTES * 100 - 1);
    localparam logic [IFG_W-1:0] IFG_100M = IFG_W'(IFG_BYTES * 10 - 1);
    localparam logic [IFG_W-1:0] IFG_1G   = IFG_W'(IFG_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        PAYLOAD,
        PAD,
        FCS,
        DROP,
        IFG
    } state_t;

    state_t           state_reg, state_next;
    logic [7:0]       tdata_reg, tdata_next;
    logic             tvalid_reg, tvalid_next;
    logic [2:0]       pre_cnt_reg, pre_cnt_next;
    logic [10:0]      count_reg, count_next;
    logic [31:0]      crc_reg, crc_next;
    logic [2:0]       fcs_cnt_reg, fcs_cnt_next;
    logic             bad_reg, bad_next;
    logic             drop_reg, drop_next;
    logic             underflow_reg, underflow_next;
    logic [IFG_W-1:0] ifg_reg, ifg_next;

    logic             s_ready;
    logic             handshake;
    logic [11:0]      count_plus;
    logic [10:0]      count_sat;
    logic [31:0]      fcs_word;
    logic [IFG_W-1:0] ifg_load;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] r;
        r = crc ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign handshake  = tvalid_reg & m_axis_tready;
    assign count_plus = {1'b0, count_reg} + 12'd1;
    assign count_sat  = count_plus[11] ? 11'h7FF : count_plus[10:0];
    // A bad frame carries the raw register instead of its complement, i.e. the inverted FCS.
    assign fcs_word   = bad_reg ? crc_reg : ~crc_reg;

    always_comb begin
        case (phy_speed_status)
            2'd0:    ifg_load = IFG_10M;
            2'd1:    ifg_load = IFG_100M;
            default: ifg_load = IFG_1G;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        tdata_next     = tdata_reg;
        tvalid_next    = tvalid_reg;
        pre_cnt_next   = pre_cnt_reg;
        count_next     = count_reg;
        crc_next       = crc_reg;
        fcs_cnt_next   = fcs_cnt_reg;
        bad_next       = bad_reg;
        drop_next      = drop_reg;
        ifg_next       = ifg_reg;
        underflow_next = 1'b0;
        s_ready        = 1'b0;

        case (state_reg)
            IDLE: begin
                count_next   = '0;
                crc_next     = CRC_INIT;
                pre_cnt_next = '0;
                fcs_cnt_next = '0;
                bad_next     = 1'b0;
                drop_next    = 1'b0;
                if (s_axis_tvalid) begin
                    state_next  = PREAMBLE;
                    tvalid_next = 1'b1;
                    tdata_next  = 8'h55;
                end
            end
            PREAMBLE: begin
                // The SFD is loaded on the seventh 0x55 handshake; its own handshake pulls the first payload byte.
                if (handshake) begin
                    if (pre_cnt_reg == 3'd6) begin
                        tdata_next = 8'hD5;
                        state_next = PAYLOAD;
                    end else begin
                        pre_cnt_next = pre_cnt_reg + 3'd1;
                    end
                end
            end
            PAYLOAD: begin
                s_ready = m_axis_tready;
                if (handshake) begin
                    if (s_axis_tvalid) begin
                        tdata_next = s_axis_tdata;
                        crc_next   = crc_byte(crc_reg, s_axis_tdata);
                        count_next = count_sat;
                        if (s_axis_tlast) begin
                            bad_next   = s_axis_tuser;
                            state_next = (PAD_ENABLE && (count_plus < MIN_LEN)) ? PAD : FCS;
                        end
                    end else begin
                        // Underflow: the current byte is gone, so the first inverted FCS byte goes out now.
                        underflow_next = 1'b1;
                        bad_next       = 1'b1;
                        tdata_next     = crc_reg[7:0];
                        fcs_cnt_next   = 3'd1;
                        drop_next      = ~s_axis_tlast;
                        state_next     = FCS;
                    end
                end
            end
            PAD: begin
                if (handshake) begin
                    tdata_next = 8'h00;
                    crc_next   = crc_byte(crc_reg, 8'h00);
                    count_next = count_sat;
                    if (count_plus >= MIN_LEN) begin
                        state_next = FCS;
                    end
                end
            end
            FCS: begin
                if (handshake) begin
                    if (fcs_cnt_reg == 3'd4) begin
                        tvalid_next = 1'b0;
                        tdata_next  = 8'h00;
                        if (drop_reg) begin
                            state_next = DROP;
                        end else begin
                            state_next = IFG;
                            ifg_next   = ifg_load;
                        end
                    end else begin
                        tdata_next   = fcs_word[{fcs_cnt_reg[1:0], 3'b000} +: 8];
                        fcs_cnt_next = fcs_cnt_reg + 3'd1;
                    end
                end
            end
            DROP: begin
                s_ready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    state_next = IFG;
                    ifg_next   = ifg_load;
                end
            end
            IFG: begin
                if (ifg_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    ifg_next = ifg_reg - 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                tvalid_next = 1'b0;
                tdata_next  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk_125mhz) begin
        if (reset) begin
            state_reg     <= IDLE;
            tdata_reg     <= 8'h00;
            tvalid_reg    <= 1'b0;
            pre_cnt_reg   <= '0;
            count_reg     <= '0;
            crc_reg       <= CRC_INIT;
            fcs_cnt_reg   <= '0;
            bad_reg       <= 1'b0;
            drop_reg      <= 1'b0;
            underflow_reg <= 1'b0;
            ifg_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            tdata_reg     <= tdata_next;
            tvalid_reg    <= tvalid_next;
            pre_cnt_reg   <= pre_cnt_next;
            count_reg     <= count_next;
            crc_reg       <= crc_next;
            fcs_cnt_reg   <= fcs_cnt_next;
            bad_reg       <= bad_next;
            drop_reg      <= drop_next;
            underflow_reg <= underflow_next;
            ifg_reg       <= ifg_next;
        end
    end

    assign s_axis_tready = s_ready;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tvalid = tvalid_reg;
    assign tx_busy       = (state_reg != IDLE);
    assign tx_underflow  = underflow_reg;

endmodule

// File: tb/tb_eth_mac_tx.sv
// Bench for eth_mac_tx: frame table plus hand-written known-answer and reset sequences, scoreboard on m_axis.
module tb_eth_mac_tx;

    localparam int IFG_BYTES   = 12;
    localparam int MIN_PAYLOAD = 60;

    logic       clk_125mhz = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] phy_speed_status = 2'd2;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tlast = 1'b0;
    logic       s_axis_tuser = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       tx_busy;
    logic       tx_underflow;

    eth_mac_tx #(
        .IFG_BYTES  (IFG_BYTES),
        .MIN_PAYLOAD(MIN_PAYLOAD)
    ) dut (
        .clk_125mhz      (clk_125mhz),
        .reset           (reset),
        .phy_speed_status(phy_speed_status),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tlast    (s_axis_tlast),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tready   (s_axis_tready),
        .m_axis_tdata    (m_axis_tdata),
        .m_axis_tvalid   (m_axis_tvalid),
        .m_axis_tready   (m_axis_tready),
        .tx_busy         (tx_busy),
        .tx_underflow    (tx_underflow)
    );

    always #4 clk_125mhz = ~clk_125mhz;

    typedef struct {
        int         len;
        logic [7:0] base;
        bit         tuser;
        int         gap_at;
        logic [1:0] speed;
        int         rdy;
        int         late_at;
        logic [1:0] late_speed;
        int         exp_ifg;
        int         exp_uf;
    } vec_t;

    int         errors = 0;
    int         checks = 0;
    int         hs_cnt = 0;
    int         uf_cnt = 0;
    int         ifg_cnt = 0;
    int         cyc = 0;
    int         rdy_period = 1;
    bit         s_acc = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] pl[0:255];
    vec_t       vecs[8];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // One clock: observe at the falling edge, then advance m_axis_tready just after the rising edge.
    task automatic step();
        logic [7:0] e;
        @(negedge clk_125mhz);
        s_acc = s_axis_tvalid && s_axis_tready;
        if (m_axis_tvalid && m_axis_tready) begin
            hs_cnt++;
            if (exp_q.size() == 0) begin
                check("extra_byte", int'(m_axis_tdata), -1);
            end else begin
                e = exp_q.pop_front();
                check("out_byte", int'(m_axis_tdata), int'(e));
            end
        end
        if (tx_underflow) uf_cnt++;
        if (tx_busy && !m_axis_tvalid && !s_axis_tready) ifg_cnt++;
        @(posedge clk_125mhz);
        #1;
        cyc++;
        m_axis_tready = (rdy_period <= 1) ? 1'b1 : ((cyc % rdy_period) == 0);
    endtask

    task automatic push_frame(input int n_acc, input int len, input bit bad, input bit aborted);
        logic [31:0] crc;
        logic [31:0] fcs;
        crc = 32'hFFFFFFFF;
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < n_acc; k++) begin
            exp_q.push_back(pl[k]);
            crc = crc_model(crc, pl[k]);
        end
`ifdef ETH_TX_PAD_EN
        if (!aborted) begin
            for (int k = len; k < MIN_PAYLOAD; k++) begin
                exp_q.push_back(8'h00);
                crc = crc_model(crc, 8'h00);
            end
        end
`else
        if (aborted && len < 0) exp_q.push_back(8'h00);
`endif
        fcs = bad ? crc : ~crc;
        for (int k = 0; k < 4; k++) exp_q.push_back(fcs[8*k +: 8]);
    endtask

    task automatic run_frame(input string tag, input int len, input bit tuser, input int gap_at,
                             input int late_at, input logic [1:0] late_speed,
                             input int exp_ifg, input int exp_uf, input bit model_push);
        int hs0, uf0, ifg0, exp_hs, idx, budget;
        bit gap_done;
        hs0 = hs_cnt; uf0 = uf_cnt; ifg0 = ifg_cnt;
        idx = 0; budget = 0; gap_done = 1'b0;
        if (model_push) push_frame((gap_at >= 0) ? gap_at : len, len, tuser || (gap_at >= 0), gap_at >= 0);
        exp_hs = exp_q.size();
        while (idx < len && budget < 20000) begin
            if (idx == gap_at && !gap_done) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast  = 1'b0;
                s_axis_tuser  = 1'b0;
                gap_done      = 1'b1;
                step();
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = pl[idx];
                s_axis_tlast  = (idx == len - 1);
                s_axis_tuser  = tuser && (idx == len - 1);
                step();
                if (s_acc) idx++;
                if (idx == late_at) phy_speed_status = late_speed;
            end
            budget++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        while (tx_busy && budget < 20000) begin
            step();
            budget++;
        end
        check({tag, "_done"}, int'(budget < 20000), 1);
        step();
        check({tag, "_handshakes"}, hs_cnt - hs0, exp_hs);
        check({tag, "_underflow"}, uf_cnt - uf0, exp_uf);
        check({tag, "_ifg"}, ifg_cnt - ifg0, exp_ifg);
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
        $display("frame %s len=%0d handshakes=%0d ifg=%0d underflow=%0d",
                 tag, len, hs_cnt - hs0, ifg_cnt - ifg0, uf_cnt - uf0);
    endtask

    initial begin
        logic [7:0] kat[0:3];
        int idx;
        int budget;

        vecs[0] = '{1,  8'hAA, 1'b0, -1, 2'd2, 1,  -1, 2'd2, 12,   0};
        vecs[1] = '{64, 8'h10, 1'b0, -1, 2'd1, 10, -1, 2'd1, 120,  0};
        vecs[2] = '{40, 8'h20, 1'b0, 20, 2'd2, 1,  -1, 2'd2, 12,   1};
        vecs[3] = '{64, 8'h30, 1'b1, -1, 2'd2, 1,  -1, 2'd2, 12,   0};
        vecs[4] = '{20, 8'h40, 1'b0, -1, 2'd0, 1,  -1, 2'd0, 1200, 0};
        vecs[5] = '{30, 8'h50, 1'b0, -1, 2'd2, 1,  5,  2'd1, 120,  0};
        vecs[6] = '{59, 8'h60, 1'b0, -1, 2'd1, 1,  10, 2'd2, 12,   0};
        vecs[7] = '{60, 8'h70, 1'b0, -1, 2'd2, 1,  -1, 2'd2, 12,   0};

        reset = 1'b1;
        repeat (3) step();
        check("reset_m_tvalid", int'(m_axis_tvalid), 0);
        check("reset_m_tdata", int'(m_axis_tdata), 0);
        check("reset_s_tready", int'(s_axis_tready), 0);
        check("reset_tx_busy", int'(tx_busy), 0);
        check("reset_underflow", int'(tx_underflow), 0);
        reset = 1'b0;
        step();

        // Known answer: "123456789" gives CRC-32 0xCBF43926, sent LSB first.
        kat[0] = 8'h26; kat[1] = 8'h39; kat[2] = 8'hF4; kat[3] = 8'hCB;
        for (int k = 0; k < 9; k++) pl[k] = 8'h31 + 8'(k);
        rdy_period = 1;
        phy_speed_status = 2'd2;
`ifdef ETH_TX_PAD_EN
        run_frame("ascii", 9, 1'b0, -1, -1, 2'd2, 12, 0, 1'b1);
`else
        for (int k = 0; k < 7; k++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int k = 0; k < 9; k++) exp_q.push_back(pl[k]);
        for (int k = 0; k < 4; k++) exp_q.push_back(kat[k]);
        run_frame("ascii", 9, 1'b0, -1, -1, 2'd2, 12, 0, 1'b0);
`endif

        for (int v = 0; v < 8; v++) begin
            for (int k = 0; k < vecs[v].len; k++) pl[k] = vecs[v].base + 8'(k * 13);
            rdy_period = vecs[v].rdy;
            phy_speed_status = vecs[v].speed;
            run_frame($sformatf("vec%0d", v), vecs[v].len, vecs[v].tuser, vecs[v].gap_at,
                      vecs[v].late_at, vecs[v].late_speed, vecs[v].exp_ifg, vecs[v].exp_uf, 1'b1);
        end

        // Reset in the middle of the payload, then a clean frame.
        rdy_period = 1;
        phy_speed_status = 2'd2;
        for (int k = 0; k < 50; k++) pl[k] = 8'hC0 ^ 8'(k);
        push_frame(50, 50, 1'b0, 1'b0);
        idx = 0;
        budget = 0;
        while (idx < 30 && budget < 1000) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = pl[idx];
            s_axis_tlast  = 1'b0;
            step();
            if (s_acc) idx++;
            budget++;
        end
        check("midreset_reached", idx, 30);
        reset = 1'b1;
        s_axis_tvalid = 1'b0;
        step();
        check("midreset_m_tvalid", int'(m_axis_tvalid), 0);
        check("midreset_tx_busy", int'(tx_busy), 0);
        check("midreset_s_tready", int'(s_axis_tready), 0);
        check("midreset_m_tdata", int'(m_axis_tdata), 0);
        check("midreset_underflow", int'(tx_underflow), 0);
        $display("frame midreset len=50 aborted after %0d accepted bytes", idx);
        exp_q.delete();
        reset = 1'b0;
        step();
        for (int k = 0; k < 64; k++) pl[k] = 8'h5A + 8'(k * 7);
        run_frame("postreset", 64, 1'b0, -1, -1, 2'd2, 12, 0, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
